// File: rtl/picomem_pkg.sv
// picomem_pkg: FSM state encoding and byte-lane constant shared by picomem_sram
package picomem_pkg;
    typedef enum logic [1:0] {IDLE, RD_WAIT, RESP} state_t;
    localparam int LANES = 4;
endpackage

// File: rtl/picomem_array.sv
// picomem_array: single-port byte-writable 32-bit RAM, no reset
module picomem_array import picomem_pkg::*; #(
  parameter int    ADDR_WIDTH = 10,
  parameter string INIT_FILE  = ""
) (
  input  logic                  clk,
  input  logic                  i_en,
  input  logic [LANES-1:0]      i_we,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [31:0]           i_wdata,
  output logic [31:0]           o_rdata
);
  logic [31:0] r_mem [2**ADDR_WIDTH];
  always_ff @(posedge clk) begin
    if (i_en) begin
      for (int i = 0; i < LANES; i++)
        if (i_we[i]) r_mem[i_addr][8*i +: 8] <= i_wdata[8*i +: 8];
      if (i_we == '0) o_rdata <= r_mem[i_addr];
    end
  end
endmodule

// File: rtl/picomem_sram.sv
// picomem_sram: PicoRV32 native-bus SRAM with optional output register and low-word write protection
module picomem_sram import picomem_pkg::*; #(
    parameter int          ADDR_WIDTH = 10,
    parameter int          OUT_REG    = 0,
    parameter int unsigned WP_WORDS   = 256,
    parameter string       INIT_FILE  = ""
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             mem_valid,
    output logic             mem_ready,
    input  logic [31:0]      mem_addr,
    input  logic [31:0]      mem_wdata,
    input  logic [LANES-1:0] mem_wstrb,
    output logic [31:0]      mem_rdata,
    input  logic             wp_lock,
    output logic             wp_err
);
    state_t r_state, w_next;
    logic [1:0] r_sync;
    logic [ADDR_WIDTH-1:0] w_idx;
    logic [31:0] r_hold, w_q;
    logic w_rst_n, w_acc, w_rd, w_blk, r_lock, r_rd, w_unused;

    always_ff @(posedge clk or negedge resetn)
        if (!resetn) r_sync <= '0;
        else r_sync <= {r_sync[0], 1'b1};

    assign w_rst_n  = r_sync[1];
    assign w_idx    = mem_addr[ADDR_WIDTH+1:2];
    assign w_unused = ^{mem_addr[31:ADDR_WIDTH+2], mem_addr[1:0]};
    assign w_rd     = mem_wstrb == '0;
    assign w_acc    = w_rst_n && r_state == IDLE && mem_valid;
    // a lock request in the accept cycle already blocks that write
    assign w_blk    = !w_rd && (r_lock || wp_lock) && 32'(w_idx) < WP_WORDS;

    picomem_array #(.ADDR_WIDTH(ADDR_WIDTH), .INIT_FILE(INIT_FILE)) u_array (
        .clk     (clk),
        .i_en    (w_acc && !w_blk),
        .i_we    (mem_wstrb),
        .i_addr  (w_idx),
        .i_wdata (mem_wdata),
        .o_rdata (w_q)
    );

    always_comb
        w_next = r_state == IDLE    ? (w_acc ? ((w_rd && OUT_REG != 0) ? RD_WAIT : RESP) : IDLE) :
                 r_state == RD_WAIT ? RESP : IDLE;

    always_ff @(posedge clk or negedge w_rst_n)
        if (!w_rst_n) begin
            r_state <= IDLE;
            r_lock  <= 1'b0;
            r_rd    <= 1'b0;
            r_hold  <= '0;
            wp_err  <= 1'b0;
        end else begin
            r_state <= w_next;
            if (wp_lock) r_lock <= 1'b1;
            if (w_acc) r_rd <= w_rd;
            if (w_acc && w_blk) wp_err <= 1'b1;
            if (OUT_REG != 0 ? (r_state == RD_WAIT) : (r_state == RESP && r_rd)) r_hold <= w_q;
        end

    assign mem_ready = r_state == RESP;
    // unregistered mode passes the RAM port through only during a read response
    assign mem_rdata = (OUT_REG == 0 && r_state == RESP && r_rd) ? w_q : r_hold;
endmodule
